// File: rtl/multiexp_g1_axi_stream_wr_master.sv
// multiexp_g1_axi_stream_wr_master: drains an AXI4-Stream into memory as AXI4 INCR write bursts.
// One AW per burst of up to BURST_LEN beats; W beats flow only for bursts whose AW is accepted.
module multiexp_g1_axi_stream_wr_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 64,
  parameter int C_MAX_OUTSTANDING  = 32
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            ctrl_start,
  output logic                            ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam int DWB = C_M_AXI_DATA_WIDTH / 8;
  localparam int BL = (4096 / DWB < 256) ? 4096 / DWB : 256;
  localparam int LDW = $clog2(DWB);
  localparam int LB = $clog2(BL);
  localparam int BURST_BYTES = BL * DWB;
  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [7:0] awlen_q, awlen_d, beat_q, beat_d, cur_len;
  logic awvalid_q, awvalid_d, done_q, done_d;
  logic [XW-1:0] beats_q, beats_d, bursts_q, bursts_d;
  logic [XW-1:0] aw_cnt_q, aw_cnt_d, b_cnt_q, b_cnt_d, wb_q, wb_d;
  logic [XW-1:0] start_beats, start_bursts;
  logic [OW-1:0] out_q, out_d;
  logic run, allowed, aw_fire, w_fire, b_fire;

  // Length field of the final burst: remaining beats minus one.
  function automatic logic [7:0] last_len(input logic [XW-1:0] beats);
    return 8'((beats - XW'(1)) & XW'(BL - 1));
  endfunction

  assign start_beats  = (ctrl_xfer_size_in_bytes >> LDW) + XW'(|(ctrl_xfer_size_in_bytes & XW'(DWB - 1)));
  assign start_bursts = (start_beats >> LB) + XW'(|(start_beats & XW'(BL - 1)));
  assign run     = state_q == RUN;
  assign allowed = run & (wb_q < aw_cnt_q);
  assign cur_len = (wb_q == bursts_q - XW'(1)) ? last_len(beats_q) : 8'(BL - 1);
  assign aw_fire = awvalid_q & m_axi_awready;
  assign w_fire  = s_axis_tvalid & m_axi_wready & allowed;
  assign b_fire  = m_axi_bvalid & run;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_wvalid  = s_axis_tvalid & allowed;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = allowed & (beat_q == cur_len);
  assign m_axi_bready  = run;
  assign s_axis_tready = m_axi_wready & allowed;
  assign ctrl_done     = done_q;

  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    bursts_d = bursts_q;
    aw_cnt_d = aw_cnt_q + XW'(aw_fire);
    b_cnt_d  = b_cnt_q + XW'(b_fire);
    out_d    = out_q + OW'(aw_fire) - OW'(b_fire);
    awaddr_d = aw_fire ? awaddr_q + AW'(BURST_BYTES) : awaddr_q;
    wb_d     = wb_q;
    beat_d   = beat_q;
    done_d   = 1'b0;
    if (w_fire) begin
      beat_d = (beat_q == cur_len) ? 8'd0 : beat_q + 8'd1;
      wb_d   = (beat_q == cur_len) ? wb_q + XW'(1) : wb_q;
    end
    case (state_q)
      IDLE: if (ctrl_start) begin
        beats_d  = start_beats;
        bursts_d = start_bursts;
        awaddr_d = ctrl_addr_offset;
        aw_cnt_d = '0;
        b_cnt_d  = '0;
        out_d    = '0;
        wb_d     = '0;
        beat_d   = '0;
        state_d  = (ctrl_xfer_size_in_bytes == '0) ? DONE : RUN;
      end
      RUN: if (b_cnt_d == bursts_q) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      // Zero-size transfers reach DONE without a pulse; emit it one cycle later.
      DONE: begin
        done_d  = ~done_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    awvalid_d = (state_d == RUN) & (aw_cnt_d < bursts_d) & (out_d < OW'(C_MAX_OUTSTANDING));
    awlen_d   = (aw_cnt_d == bursts_d - XW'(1)) ? last_len(beats_d) : 8'(BL - 1);
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      done_q    <= 1'b0;
      beats_q   <= '0;
      bursts_q  <= '0;
      aw_cnt_q  <= '0;
      b_cnt_q   <= '0;
      out_q     <= '0;
      wb_q      <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      done_q    <= done_d;
      beats_q   <= beats_d;
      bursts_q  <= bursts_d;
      aw_cnt_q  <= aw_cnt_d;
      b_cnt_q   <= b_cnt_d;
      out_q     <= out_d;
      wb_q      <= wb_d;
      beat_q    <= beat_d;
    end
  end
endmodule

// File: doc/multiexp_g1_axi_stream_wr_master.md
Name: multiexp_g1_axi_stream_wr_master

Overview:
- AXI4 write master that drains an AXI4-Stream of result data into device memory as INCR bursts, from a programmed start address for a programmed byte count.
- Write-side counterpart of the kernel's stream-producing AXI read masters.
- Sits between the bn128 multiexp result interface and the result AXI4 port.
- Pulses ctrl_done once every issued burst has received its B response.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, AXI address width.
- C_M_AXI_DATA_WIDTH, 512, AXI and stream data width in bits; power of 2, ≥32.
- C_XFER_SIZE_WIDTH, 64, width of the byte-count input.
- C_MAX_OUTSTANDING, 32, maximum bursts with AW accepted and B not yet received; ≥1.
- Derived: DW_BYTES = C_M_AXI_DATA_WIDTH/8; BURST_LEN = min(4096/DW_BYTES, 256), which is 64 at the default width.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- ctrl_start  in  1  start pulse; sampled in IDLE only.
- ctrl_done  out  1  one-cycle completion pulse.
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  start byte address; DW_BYTES-aligned.
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  bytes to write.
- m_axi_awvalid  out  1  AW valid.
- m_axi_awready  in  1  AW ready.
- m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH  burst address.
- m_axi_awlen  out  8  beats-1.
- m_axi_wvalid  out  1  W valid.
- m_axi_wready  in  1  W ready.
- m_axi_wdata  out  C_M_AXI_DATA_WIDTH  write data.
- m_axi_wstrb  out  DW_BYTES  byte strobes.
- m_axi_wlast  out  1  last beat of burst.
- m_axi_bvalid  in  1  B valid.
- m_axi_bready  out  1  B ready.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tdata  in  C_M_AXI_DATA_WIDTH  stream data.

Behaviour:
- Clock ap_clk; reset areset, synchronous, active-high. Reset is effective at any time, including mid-transfer: all counters clear, state returns to IDLE, and any in-flight AXI transaction is abandoned.
- Reset values: awvalid 0, wvalid 0, wlast 0, bready 0, s_axis_tready 0, ctrl_done 0, awaddr 0, awlen 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On ctrl_start, latch the address and compute total_beats = ceil(size/DW_BYTES) and total_bursts = ceil(total_beats/BURST_LEN).
  - If size=0, go to DONE; otherwise go to RUN.
  - ctrl_start outside IDLE is ignored.
- RUN, AW channel:
  - awvalid asserts the cycle after start and stays high, with awaddr/awlen stable, until awready.
  - Burst k: awaddr = offset + k·BURST_LEN·DW_BYTES; awlen = BURST_LEN-1, except the final burst, which uses awlen = total_beats - (total_bursts-1)·BURST_LEN - 1.
  - A new AW is presented only while outstanding < C_MAX_OUTSTANDING, where outstanding = aw_accepted - b_received. It is incremented on AW handshake and decremented on B handshake; a simultaneous AW and B handshake leaves it unchanged.
  - No further AW after total_bursts.
- RUN, W channel:
  - W beats are allowed only for bursts whose AW has already been accepted: w_bursts_done < aw_accepted.
  - wvalid = s_axis_tvalid & allowed.
  - s_axis_tready = m_axi_wready & allowed.
  - wdata = s_axis_tdata, combinational pass-through; wstrb all ones.
  - wlast = 1 on the beat whose in-burst index equals that burst's awlen. The in-burst beat counter wraps to 0 after wlast and w_bursts_done increments.
  - No W beats after total_beats, including when extra stream data is present; tready stays 0.
- RUN, B channel: bready = 1 throughout RUN. B responses are counted; bresp is not checked.
- RUN → DONE when b_received = total_bursts.
- DONE: ctrl_done = 1 for exactly one cycle, then return to IDLE.
- Latency: size>0 → ctrl_done is asserted the cycle after the last B handshake. size=0 → ctrl_done is asserted 2 cycles after ctrl_start.
- 4 KB boundary rule: bursts never cross a 4 KB boundary provided ctrl_addr_offset is 4 KB-aligned; callers guarantee this.
- Widths:
  - Beat and burst counters are C_XFER_SIZE_WIDTH bits.
  - The outstanding counter is clog2(C_MAX_OUTSTANDING+1) bits.
  - Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH.

Test Plan:
- Size 96, offset 0x1000, readies high → one AW with awaddr=0x1000, awlen=1; 2 W beats with wlast on beat 2; done 1 cycle after bvalid.
- Size 8192, offset 0 → two AWs (0x0 len 63, 0x1000 len 63); 128 beats; wlast on beats 64 and 128; one done pulse.
- Size 4160, C_MAX_OUTSTANDING=1, bvalid held low for 50 cycles → second AW (0x1000, len 0) is withheld until the first B arrives; ctrl_done stays 0 until the second B.
- Size 0 → no AW/W activity; ctrl_done high exactly 2 cycles after start.
- Random wready/tvalid/awready throttling, size 20000 → 313 beats, bursts 4×len63 + len56, data order preserved, tready only under the gating rule.
- areset asserted mid-burst, then a new start with size 128 → all outputs 0 the cycle after reset; the new transfer completes with a single AW of len 1.
